// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction field layout, HALT opcode and fetch FSM states.
// Used by fetch_cpu, prog_mem and decoder_cpu.
package cpu_pkg;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;
  localparam int FUNC_W   = 2;

  localparam logic [OPCODE_W-1:0] HALT_OP = 6'b111111;

  localparam int OPC_MSB  = 7;
  localparam int OPC_LSB  = 2;
  localparam int FUNC_MSB = 1;
  localparam int FUNC_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [FUNC_W-1:0] get_func(input logic [INSTR_W-1:0] instr);
    return instr[FUNC_MSB:FUNC_LSB];
  endfunction

endpackage

// File: rtl/fetch_cpu_prog_mem.sv
// Program memory: one write port, one synchronous read port with read enable.
// No reset; the read register holds its value whenever re is low.
module prog_mem #(
  parameter int ADDR_W = 8
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             waddr,
  input  logic [cpu_pkg::INSTR_W-1:0]   wdata,
  input  logic                          re,
  input  logic [ADDR_W-1:0]             raddr,
  output logic [cpu_pkg::INSTR_W-1:0]   rdata
);
  import cpu_pkg::*;

  logic [INSTR_W-1:0] r_mem [2**ADDR_W];
  logic [INSTR_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/fetch_cpu.sv
// Instruction fetch stage feeding decoder_cpu: PC sequencing, stall/jump/halt
// control and a loadable program memory whose read register forms the code output.
module fetch_cpu #(
  parameter int                            ADDR_W  = 8,
  parameter logic [ADDR_W-1:0]             PC_RST  = '0,
  parameter logic [cpu_pkg::OPCODE_W-1:0]  HALT_OP = cpu_pkg::HALT_OP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  output logic [31:0]       code,
  output logic              en_de,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              halted
);
  import cpu_pkg::*;

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_pc, r_pc_out;
  logic              r_en_de;
  logic              r_has_data;
  logic [31:0]       w_rdata, w_code;
  logic              w_fetch, w_jump, w_halt, w_start, w_prog_we;

  prog_mem #(.ADDR_W(ADDR_W)) u_prog_mem (
    .clk   (clk),
    .we    (w_prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (w_fetch),
    .raddr (r_pc),
    .rdata (w_rdata)
  );

  // The RAM read register has no reset, so code is masked until the first fetch.
  assign w_code = r_has_data ? w_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_fetch      = 1'b0;
    w_jump       = 1'b0;
    w_halt       = 1'b0;
    w_start      = 1'b0;
    w_prog_we    = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALTED: begin
        w_prog_we = prog_we;
        if (start) begin
          w_start      = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (jump_en) begin
          w_jump = 1'b1;
        end else if (r_en_de && get_opcode(w_code) == HALT_OP && !stall) begin
          w_halt       = 1'b1;
          w_state_next = ST_HALTED;
        end else if (!stall) begin
          w_fetch = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= PC_RST;
      r_pc_out   <= '0;
      r_en_de    <= 1'b0;
      r_has_data <= 1'b0;
    end else begin
      if (w_start) begin
        r_pc    <= PC_RST;
        r_en_de <= 1'b0;
      end
      if (w_jump) begin
        r_pc    <= jump_addr;
        r_en_de <= 1'b0;
      end
      if (w_halt) r_en_de <= 1'b0;
      if (w_fetch) begin
        r_pc_out   <= r_pc;
        r_pc       <= r_pc + 1'b1;
        r_en_de    <= 1'b1;
        r_has_data <= 1'b1;
      end
    end
  end

  assign code   = w_code;
  assign en_de  = r_en_de;
  assign pc_out = r_pc_out;
  assign busy   = (r_state == ST_RUN);
  assign halted = (r_state == ST_HALTED);

endmodule

// File: tb/tb_fetch_cpu.sv
// Scoreboard bench for fetch_cpu: directed programs push expected (code, pc_out)
// pairs; a negedge monitor pops one per word accepted downstream (en_de && !stall).
module tb_fetch_cpu;

  typedef struct {
    logic [31:0] code;
    logic [7:0]  pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        jump_en = 1'b0;
  logic [7:0]  jump_addr = '0;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic [31:0] code;
  logic        en_de;
  logic [7:0]  pc_out;
  logic        busy;
  logic        halted;

  int total = 0;
  int bad   = 0;
  exp_t sb_q[$];

  localparam logic [31:0] W0   = 32'h00010200;
  localparam logic [31:0] W1   = 32'h00000304;
  localparam logic [31:0] WH   = 32'h000000FC;
  localparam logic [31:0] W16  = 32'hABCD0010;
  localparam logic [31:0] W254 = 32'h11110008;
  localparam logic [31:0] W255 = 32'h2222000C;

  fetch_cpu #(.ADDR_W(8), .PC_RST(8'd0), .HALT_OP(6'b111111)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stall     (stall),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .code      (code),
    .en_de     (en_de),
    .pc_out    (pc_out),
    .busy      (busy),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] c, input logic [7:0] p);
    exp_t e;
    e.code = c;
    e.pc   = p;
    sb_q.push_back(e);
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic wait_halted(input string name);
    int n = 0;
    while (!halted && n < 60) begin
      tick();
      n++;
    end
    chk({name, "_halted"}, {31'd0, halted}, 32'd1);
    chk({name, "_en_de_off"}, {31'd0, en_de}, 32'd0);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Monitor: one scoreboard pop per accepted word.
  always @(negedge clk) begin
    if (!rst && en_de === 1'b1 && stall === 1'b0) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL mon_unexpected: got code=%h pc=%0d expected no word", code, pc_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (code !== e.code || pc_out !== e.pc) begin
          bad++;
          $display("FAIL mon_word: got code=%h pc=%0d expected code=%h pc=%0d",
                   code, pc_out, e.code, e.pc);
        end else begin
          $display("ok   mon_word: code=%h pc=%0d", code, pc_out);
        end
      end
    end
  end

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_code",   code,             32'd0);
    chk("rst_en_de",  {31'd0, en_de},   32'd0);
    chk("rst_pc_out", {24'd0, pc_out},  32'd0);
    chk("rst_busy",   {31'd0, busy},    32'd0);
    chk("rst_halted", {31'd0, halted},  32'd0);
    tick();
    rst = 1'b0;
    tick();

    load(8'd0, W0);   load(8'd1, W1);    load(8'd2, WH);
    load(8'd16, W16); load(8'd17, WH);
    load(8'd254, W254); load(8'd255, W255);

    // Straight-line run to HALT
    push(W0, 8'd0); push(W1, 8'd1); push(WH, 8'd2);
    pulse_start();
    chk("start_busy",  {31'd0, busy},  32'd1);
    chk("start_en_de", {31'd0, en_de}, 32'd0);
    tick();
    chk("first_en_de", {31'd0, en_de}, 32'd1);
    chk("first_code",  code,           W0);
    wait_halted("run1");
    chk("halt_code_kept", code,            WH);
    chk("halt_pc_kept",   {24'd0, pc_out}, 32'd2);

    // Stall for 3 cycles while W1 is presented
    push(W0, 8'd0); push(W1, 8'd1); push(WH, 8'd2);
    pulse_start();
    tick();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_code_%0d", i), code,            W1);
      chk($sformatf("stall_pc_%0d", i),   {24'd0, pc_out}, 32'd1);
    end
    stall = 1'b0;
    wait_halted("stall");

    // Jump to 16 while pc=1 (W0 on code)
    push(W0, 8'd0); push(W16, 8'd16); push(WH, 8'd17);
    pulse_start();
    tick();
    jump_en = 1'b1; jump_addr = 8'h10;
    tick();
    jump_en = 1'b0;
    chk("jump_bubble", {31'd0, en_de}, 32'd0);
    tick();
    chk("jump_en_de", {31'd0, en_de},   32'd1);
    chk("jump_code",  code,             W16);
    chk("jump_pc",    {24'd0, pc_out},  32'd16);
    wait_halted("jump");

    // PC wrap 255 -> 0
    push(W0, 8'd0); push(W254, 8'd254); push(W255, 8'd255);
    push(W0, 8'd0); push(W1, 8'd1); push(WH, 8'd2);
    pulse_start();
    tick();
    jump_en = 1'b1; jump_addr = 8'd254;
    tick();
    jump_en = 1'b0;
    wait_halted("wrap");

    // Async reset mid-run, between clock edges
    push(W0, 8'd0);
    pulse_start();
    tick();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_en_de", {31'd0, en_de}, 32'd0);
    chk("arst_code",  code,           32'd0);
    chk("arst_busy",  {31'd0, busy},  32'd0);
    tick();
    rst = 1'b0;
    tick();
    push(W0, 8'd0); push(W1, 8'd1); push(WH, 8'd2);
    pulse_start();
    wait_halted("after_rst");

    // prog_we during RUN must be ignored
    push(W0, 8'd0); push(W1, 8'd1); push(WH, 8'd2);
    pulse_start();
    prog_we = 1'b1; prog_addr = 8'd0; prog_data = 32'hDEADBEEF;
    tick();
    tick();
    prog_we = 1'b0;
    wait_halted("we_run");
    push(W0, 8'd0); push(W1, 8'd1); push(WH, 8'd2);
    pulse_start();
    wait_halted("we_check");

    tick();
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
